// File: rtl/ets_pkg.sv
// Shared constants for the equivalent-time sampling sweep sequencer:
// state encoding, default index range and the vernier index width.
package ets_pkg;

  localparam int IDX_W         = 7;
  localparam int IDX_FIRST_DEF = 2;
  localparam int IDX_LAST_DEF  = 120;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

endpackage

// File: rtl/ets_sweep_ctrl_if.sv
// Control, capture, lookup and point-record signals of the sweep sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface ets_sweep_ctrl_if
  import ets_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] avg_count;
  logic             busy;
  logic             done;

  logic [7:0]       T;
  logic [15:0]      map_average;

  logic             cap_req;
  logic             cap_ack;

  logic             pt_valid;
  logic             pt_ready;
  logic [IDX_W-1:0] pt_index;
  logic [15:0]      pt_offset;
  logic             pt_last;

  modport slave (
    input  start, abort, avg_count, map_average, cap_ack, pt_ready,
    output busy, done, T, cap_req, pt_valid, pt_index, pt_offset, pt_last
  );

  modport master (
    output start, abort, avg_count, map_average, cap_ack, pt_ready,
    input  busy, done, T, cap_req, pt_valid, pt_index, pt_offset, pt_last
  );

endinterface

// File: rtl/ets_settle_timer.sv
// Settle down-counter: load on entry to SETTLE, count down, expire at zero.
module ets_settle_timer #(
  parameter int SETTLE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int         W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYC - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/ets_sweep_ctrl.sv
// Equivalent-time sampling sweep sequencer: steps the vernier index, settles,
// issues a programmable number of captures per point and emits point records.
module ets_sweep_ctrl
  import ets_pkg::*;
#(
  parameter int IDX_FIRST  = IDX_FIRST_DEF,
  parameter int IDX_LAST   = IDX_LAST_DEF,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst_n,
  ets_sweep_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(IDX_FIRST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IDX_LAST);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] avg_q, avg_d, avg_eff;
  logic [IDX_W-1:0] pt_index_q, pt_index_d;
  logic [15:0]      pt_offset_q, pt_offset_d;
  logic             pt_last_q, pt_last_d;
  logic             cap_req_q, pt_valid_q, busy_q, done_q;
  logic             settle_load, settle_expired;

  // A zero capture count would never match the incremented counter.
  assign avg_eff     = (avg_q == '0) ? CNT_W'(1) : avg_q;
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign settle_load = (state_d == S_SETTLE) && (state_q != S_SETTLE);

  ets_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (settle_load),
    .en_i      (state_q == S_SETTLE),
    .expired_o (settle_expired)
  );

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    pt_index_d  = pt_index_q;
    pt_offset_d = pt_offset_q;
    pt_last_d   = pt_last_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          avg_d   = bus.avg_count;
          t_d     = FIRST_IDX;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_expired) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (bus.cap_ack) begin
          if (cnt_inc == avg_eff) begin
            cnt_d       = '0;
            pt_index_d  = t_q;
            pt_offset_d = bus.map_average;
            pt_last_d   = (t_q == LAST_IDX);
            state_d     = S_EMIT;
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: state_d = S_CAPTURE;
      S_EMIT: begin
        if (bus.pt_ready) begin
          if (pt_last_q || (t_q == LAST_IDX)) begin
            state_d = S_DONE;
          end else begin
            t_d     = t_q + IDX_W'(1);
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything; the index and the last record fields hold.
    if (bus.abort) begin
      state_d     = S_IDLE;
      t_d         = t_q;
      cnt_d       = '0;
      avg_d       = avg_q;
      pt_index_d  = pt_index_q;
      pt_offset_d = pt_offset_q;
      pt_last_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      pt_index_q  <= '0;
      pt_offset_q <= '0;
      pt_last_q   <= 1'b0;
      cap_req_q   <= 1'b0;
      pt_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      pt_index_q  <= pt_index_d;
      pt_offset_q <= pt_offset_d;
      pt_last_q   <= pt_last_d;
      cap_req_q   <= (state_d == S_CAPTURE);
      pt_valid_q  <= (state_d == S_EMIT);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.T         = {1'b0, t_q};
  assign bus.cap_req   = cap_req_q;
  assign bus.pt_valid  = pt_valid_q;
  assign bus.pt_index  = pt_index_q;
  assign bus.pt_offset = pt_offset_q;
  assign bus.pt_last   = pt_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Directed self-checking bench for ets_sweep_ctrl: two instances (index 2..4
// and a single point at 114), an auto-acking capture engine and an event log.
module tb_ets_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ets_sweep_ctrl_if #(.CNT_W(16)) ifA ();
  ets_sweep_ctrl_if #(.CNT_W(16)) ifB ();

  ets_sweep_ctrl #(.IDX_FIRST(2), .IDX_LAST(4), .SETTLE_CYC(4), .CNT_W(16)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA)
  );

  ets_sweep_ctrl #(.IDX_FIRST(114), .IDX_LAST(114), .SETTLE_CYC(4), .CNT_W(16)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB)
  );

  // Drive side (index 0 = dutA, 1 = dutB)
  logic [1:0]       startV, abortV, ptReady, ack, strayAck;
  logic [1:0][15:0] avgV;
  int               ackDelay [2];

  // Observe side
  logic [1:0][7:0]  tV;
  logic [1:0]       busyV, doneV, capReq, ptValid, ptLast;
  logic [1:0][6:0]  ptIndex;
  logic [1:0][15:0] ptOffset;

  function automatic logic [15:0] lookup(input logic [7:0] t);
    case (t)
      8'd2:    return 16'd187;
      8'd3:    return 16'd275;
      8'd4:    return 16'd33;
      8'd114:  return 16'd913;
      default: return {8'h5A, t};
    endcase
  endfunction

  assign ifA.start       = startV[0];
  assign ifA.abort       = abortV[0];
  assign ifA.avg_count   = avgV[0];
  assign ifA.pt_ready    = ptReady[0];
  assign ifA.cap_ack     = ack[0] | strayAck[0];
  assign ifA.map_average = lookup(ifA.T);
  assign ifB.start       = startV[1];
  assign ifB.abort       = abortV[1];
  assign ifB.avg_count   = avgV[1];
  assign ifB.pt_ready    = ptReady[1];
  assign ifB.cap_ack     = ack[1] | strayAck[1];
  assign ifB.map_average = lookup(ifB.T);

  assign tV       = {ifB.T, ifA.T};
  assign busyV    = {ifB.busy, ifA.busy};
  assign doneV    = {ifB.done, ifA.done};
  assign capReq   = {ifB.cap_req, ifA.cap_req};
  assign ptValid  = {ifB.pt_valid, ifA.pt_valid};
  assign ptLast   = {ifB.pt_last, ifA.pt_last};
  assign ptIndex  = {ifB.pt_index, ifA.pt_index};
  assign ptOffset = {ifB.pt_offset, ifA.pt_offset};

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Event log kinds: 0 handshake, 1 cap_req rise, 2 done pulse, 3 busy fall
  typedef struct {
    int          kind;
    int          dut;
    int          cyc;
    logic [6:0]  idx;
    logic [15:0] off;
    logic        last;
  } evT;
  evT evQ[$];

  initial begin : monitor
    logic [1:0] prevReq, prevBusy;
    prevReq  = '0;
    prevBusy = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ptValid[i] && ptReady[i]) evQ.push_back('{0, i, cyc, ptIndex[i], ptOffset[i], ptLast[i]});
        if (capReq[i] && !prevReq[i]) evQ.push_back('{1, i, cyc, 7'd0, 16'd0, 1'b0});
        if (doneV[i])                 evQ.push_back('{2, i, cyc, 7'd0, 16'd0, 1'b0});
        if (!busyV[i] && prevBusy[i]) evQ.push_back('{3, i, cyc, 7'd0, 16'd0, 1'b0});
      end
      prevReq  = capReq;
      prevBusy = busyV;
    end
  end

  // Capture engine model: ack arrives ackDelay cycles after cap_req rises.
  initial begin : capResponder
    int age [2];
    ack    = '0;
    age[0] = 0;
    age[1] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          ack[i] = 1'b0;
          age[i] = 0;
        end else if (capReq[i]) begin
          age[i]++;
          if (age[i] > ackDelay[i]) ack[i] = 1'b1;
        end else begin
          age[i] = 0;
        end
      end
    end
  end

  function automatic int countEv(input int kind, input int dut, input int base);
    int n;
    n = 0;
    for (int j = base; j < evQ.size(); j++)
      if (evQ[j].kind == kind && evQ[j].dut == dut) n++;
    return n;
  endfunction

  function automatic evT nthEv(input int kind, input int dut, input int base, input int n);
    evT r;
    int k;
    r = '{-1, -1, -1, 7'h7F, 16'hFFFF, 1'bx};
    k = 0;
    for (int j = base; j < evQ.size(); j++) begin
      if (evQ[j].kind == kind && evQ[j].dut == dut) begin
        if (k == n) return evQ[j];
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [35:0] status(input int i);
    return {tV[i], busyV[i], capReq[i], ptValid[i], doneV[i], ptLast[i], ptIndex[i], ptOffset[i]};
  endfunction

  // All stimulus changes land 1 time unit after the rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) nextCycle();
  endtask

  // One-cycle start pulse; returns in the cycle after start was sampled.
  task automatic applyStimulus(input int dut, input logic [15:0] avg);
    avgV[dut]   = avg;
    startV[dut] = 1'b1;
    nextCycle();
    startV[dut] = 1'b0;
  endtask

  task automatic waitIdle(input int dut, input int budget, input string tag);
    for (int n = 0; n < budget && busyV[dut]; n++) nextCycle();
    checkOutput(tag, busyV[dut], 1'b0);
    nextCycle();
    nextCycle();
  endtask

  initial begin : stimulus
    int   c, c2, base, base2;
    evT   e;
    logic [23:0] expRec [3];
    expRec[0] = {7'd2, 16'd187, 1'b0};
    expRec[1] = {7'd3, 16'd275, 1'b0};
    expRec[2] = {7'd4, 16'd33,  1'b1};

    rst_n       = 1'b0;
    startV      = '0;
    abortV      = '0;
    ptReady     = '0;
    strayAck    = '0;
    avgV        = '0;
    ackDelay[0] = 0;
    ackDelay[1] = 0;
    repeat (3) nextCycle();
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] reset state");
    checkOutput("rst_A", status(0), 36'd0);
    checkOutput("rst_B", status(1), 36'd0);

    $display("[TB] short sweep 2..4, one capture, ack after 3 cycles");
    ptReady[0] = 1'b1;
    ackDelay[0] = 3;
    base = evQ.size();
    c = cyc;
    applyStimulus(0, 16'd1);
    checkOutput("sweep_T_first", tV[0], 8'd2);
    checkOutput("sweep_busy", busyV[0], 1'b1);
    waitIdle(0, 100, "sweep_timeout");
    checkOutput("sweep_rec_count", countEv(0, 0, base), 3);
    for (int n = 0; n < 3; n++) begin
      e = nthEv(0, 0, base, n);
      checkOutput("sweep_rec", {e.idx, e.off, e.last}, expRec[n]);
      checkOutput("sweep_hs_cycle", e.cyc, c + 9 + 9 * n);
    end
    checkOutput("sweep_first_req", nthEv(1, 0, base, 0).cyc, c + 5);
    checkOutput("sweep_done_cycle", nthEv(2, 0, base, 0).cyc, c + 28);
    checkOutput("sweep_busy_fall", nthEv(3, 0, base, 0).cyc, c + 29);

    $display("[TB] averaging, 5 captures at index 114");
    ptReady[1] = 1'b1;
    ackDelay[1] = 0;
    base = evQ.size();
    c = cyc;
    applyStimulus(1, 16'd5);
    waitIdle(1, 100, "avg_timeout");
    checkOutput("avg_req_count", countEv(1, 1, base), 5);
    for (int n = 0; n < 5; n++)
      checkOutput("avg_req_cycle", nthEv(1, 1, base, n).cyc, c + 5 + 2 * n);
    e = nthEv(0, 1, base, 0);
    checkOutput("avg_rec", {e.idx, e.off, e.last}, {7'd114, 16'd913, 1'b1});
    checkOutput("avg_hs_cycle", e.cyc, c + 14);
    checkOutput("avg_done_cycle", nthEv(2, 1, base, 0).cyc, c + 15);

    $display("[TB] avg_count zero behaves as one");
    ackDelay[0] = 0;
    base = evQ.size();
    c = cyc;
    applyStimulus(0, 16'd0);
    waitIdle(0, 100, "zero_timeout");
    checkOutput("zero_req_count", countEv(1, 0, base), 3);
    checkOutput("zero_third_req", nthEv(1, 0, base, 2).cyc, c + 17);
    e = nthEv(0, 0, base, 2);
    checkOutput("zero_last_rec", {e.idx, e.off, e.last}, expRec[2]);

    $display("[TB] backpressure on first record");
    ptReady[0] = 1'b0;
    base = evQ.size();
    c = cyc;
    applyStimulus(0, 16'd1);
    waitCycle(c + 6);
    for (int n = 0; n < 10; n++) begin
      checkOutput("bp_hold", {ptValid[0], ptIndex[0], ptOffset[0], tV[0], capReq[0]},
                  {1'b1, 7'd2, 16'd187, 8'd2, 1'b0});
      nextCycle();
    end
    ptReady[0] = 1'b1;
    waitIdle(0, 100, "bp_timeout");
    checkOutput("bp_hs_cycle", nthEv(0, 0, base, 0).cyc, c + 16);
    checkOutput("bp_rec_count", countEv(0, 0, base), 3);
    checkOutput("bp_req_count", countEv(1, 0, base), 3);

    $display("[TB] abort during CAPTURE");
    ackDelay[0] = 2;
    base = evQ.size();
    c = cyc;
    applyStimulus(0, 16'd3);
    waitCycle(c + 6);
    checkOutput("abcap_in_capture", capReq[0], 1'b1);
    abortV[0] = 1'b1;
    nextCycle();
    abortV[0] = 1'b0;
    checkOutput("abcap_after", {busyV[0], capReq[0], ptValid[0], doneV[0], ptLast[0], tV[0]},
                {5'b00000, 8'd2});
    repeat (3) nextCycle();
    checkOutput("abcap_no_done", countEv(2, 0, base), 0);
    checkOutput("abcap_no_rec", countEv(0, 0, base), 0);

    $display("[TB] abort during EMIT, then restart with stray inputs");
    ackDelay[0] = 0;
    base = evQ.size();
    c = cyc;
    applyStimulus(0, 16'd1);
    waitCycle(c + 7);
    ptReady[0] = 1'b0;
    waitCycle(c + 12);
    checkOutput("abemit_in_emit", {ptValid[0], tV[0]}, {1'b1, 8'd3});
    abortV[0] = 1'b1;
    nextCycle();
    abortV[0] = 1'b0;
    checkOutput("abemit_after", {busyV[0], capReq[0], ptValid[0], doneV[0], ptLast[0], tV[0]},
                {5'b00000, 8'd3});
    repeat (3) nextCycle();
    checkOutput("abemit_no_done", countEv(2, 0, base), 0);
    checkOutput("abemit_rec_count", countEv(0, 0, base), 1);

    ptReady[0] = 1'b1;
    ackDelay[0] = 2;
    base2 = evQ.size();
    c2 = cyc;
    applyStimulus(0, 16'd1);
    checkOutput("restart_T_first", tV[0], 8'd2);
    waitCycle(c2 + 10);
    avgV[0]     = 16'd7;
    startV[0]   = 1'b1;
    strayAck[0] = 1'b1;
    nextCycle();
    startV[0]   = 1'b0;
    strayAck[0] = 1'b0;
    waitIdle(0, 100, "stray_timeout");
    checkOutput("stray_rec_count", countEv(0, 0, base2), 3);
    for (int n = 0; n < 3; n++) begin
      e = nthEv(0, 0, base2, n);
      checkOutput("stray_rec", {e.idx, e.off, e.last}, expRec[n]);
      checkOutput("stray_hs_cycle", e.cyc, c2 + 8 + 8 * n);
    end
    checkOutput("stray_req_count", countEv(1, 0, base2), 3);
    checkOutput("stray_done_cycle", nthEv(2, 0, base2, 0).cyc, c2 + 25);

    $display("[TB] asynchronous reset mid-SETTLE");
    c = cyc;
    applyStimulus(0, 16'd1);
    nextCycle();
    checkOutput("arst_pre_busy", {busyV[0], tV[0]}, {1'b1, 8'd2});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_A_now", status(0), 36'd0);
    checkOutput("arst_B_now", status(1), 36'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("arst_A_held", status(0), 36'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
